// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback stage.
package rf_writeback_ctrl_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rf_writeback_ctrl_extract.sv
// Load data extraction: selects byte/halfword lane and extends to XLEN.
module load_extract
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    logic        is_b;
    logic        is_h;

    assign b    = word[{offset, 3'b000} +: 8];
    assign h    = word[{offset[1], 4'b0000} +: 16];
    assign sx   = ~funct3[2];
    assign is_b = (funct3 == F3_LB) || (funct3 == F3_LBU);
    assign is_h = (funct3 == F3_LH) || (funct3 == F3_LHU);

    always_comb begin
        data = word;
        unique case (1'b1)
            is_b:    data = {{(XLEN-8){sx & b[7]}}, b};
            is_h:    data = {{(XLEN-16){sx & h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Writeback stage: ALU commits, one outstanding load, x0 suppression.
// Optional RF_WB_TIMEOUT_EN aborts a load stuck in WAIT_MEM.
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_req_valid,
    output logic            ld_req_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rf_load,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_data,
    output logic            stall,
    output logic            wb_err
);

    wb_state_t       state;
    wb_state_t       state_nxt;
    logic [AW-1:0]   ld_rd_q;
    logic [2:0]      ld_f3_q;
    logic [1:0]      ld_off_q;
    logic [XLEN-1:0] ld_data_q;
    logic [XLEN-1:0] ext_data;
    logic            ld_acc;
    logic            rsp_take;
    logic            timeout;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            wr_go;

    load_extract #(.XLEN(XLEN)) u_ext (
        .funct3 (ld_f3_q),
        .offset (ld_off_q),
        .word   (mem_rsp_data),
        .data   (ext_data)
    );

    assign ld_req_ready = (state == IDLE);
    assign stall        = (state != IDLE);
    assign ld_acc       = ld_req_valid & ld_req_ready;
    assign rsp_take     = (state == WAIT_MEM) & mem_rsp_valid;
    assign wr_go        = wr_en && (wr_addr != '0);

`ifdef RF_WB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ld_acc) begin
            cnt <= '0;
        end else if (state == WAIT_MEM) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A response on the final cycle beats the abort.
    assign timeout = (state == WAIT_MEM) && !mem_rsp_valid &&
                     (cnt == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = alu_rd;
        wr_data   = alu_result;
        unique case (state)
            IDLE: begin
                wr_en = alu_valid;
                if (ld_acc) state_nxt = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (rsp_take)     state_nxt = COMMIT;
                else if (timeout) state_nxt = IDLE;
            end
            COMMIT: begin
                wr_en     = 1'b1;
                wr_addr   = ld_rd_q;
                wr_data   = ld_data_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rf_load   <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            wb_err    <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
            ld_data_q <= '0;
        end else begin
            state   <= state_nxt;
            rf_load <= wr_go;
            wb_err  <= timeout;
            if (wr_go) begin
                rf_addr <= wr_addr;
                rf_data <= wr_data;
            end
            if (ld_acc) begin
                ld_rd_q  <= ld_rd;
                ld_f3_q  <= ld_funct3;
                ld_off_q <= ld_offset;
            end
            if (rsp_take) ld_data_q <= ext_data;
        end
    end

endmodule
